// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side bus of the load/store sequencer.
//   slave  : the sequencer's view (CPU request and RAM read data in; status, result and RAM controls out)
//   master : the environment's view (CPU stage plus data RAM), directions mirrored
interface mem_access_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    // CPU side
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rdata,
        output ready, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rdata,
        input  ready, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a word-wide, big-endian,
// byte-addressed data RAM. Turns byte/half/word requests into aligned word
// accesses, does read-modify-write for sub-word stores, and flags misaligned,
// out-of-range and illegal-size requests.
//   clk   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : CPU request/response and RAM controls (mem_access_unit_if.slave)
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic               clk,
    input  logic               Reset,
    mem_access_unit_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              accept_c;
    logic              we_q, sign_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, word_q, rdata_q;

    logic [1:0]        span_c;
    logic [ADDR_W:0]   last_byte_c;
    logic              req_err_c;
    logic [7:0]        byte_sel_c;
    logic [15:0]       half_sel_c;
    logic [DATA_W-1:0] load_ext_c, merged_c;

    // Request classification: offset of the last byte touched must stay inside the RAM
    always_comb begin
        span_c = 2'd0;
        case (bus.size)
            2'b01:   span_c = 2'd1;
            2'b10:   span_c = 2'd3;
            default: span_c = 2'd0;
        endcase
        last_byte_c = {1'b0, bus.addr} + (ADDR_W+1)'(span_c);
        req_err_c   = (bus.size == 2'b11)
                   || (bus.size == 2'b01 && bus.addr[0])
                   || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00)
                   || (last_byte_c >= (ADDR_W+1)'(MEM_BYTES));
    end

    // Load extraction from the live RAM word (big-endian: offset 0 is the MSB lane)
    always_comb begin
        byte_sel_c = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_sel_c = bus.mem_rdata[31:24];
            2'd1: byte_sel_c = bus.mem_rdata[23:16];
            2'd2: byte_sel_c = bus.mem_rdata[15:8];
            default: byte_sel_c = bus.mem_rdata[7:0];
        endcase
        half_sel_c = addr_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        case (size_q)
            2'b00:   load_ext_c = {{24{sign_q & byte_sel_c[7]}}, byte_sel_c};
            2'b01:   load_ext_c = {{16{sign_q & half_sel_c[15]}}, half_sel_c};
            default: load_ext_c = bus.mem_rdata;
        endcase
    end

    // Store merge into the word captured during RD
    always_comb begin
        merged_c = word_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged_c[31:24] = wdata_q[7:0];
                    2'd1: merged_c[23:16] = wdata_q[7:0];
                    2'd2: merged_c[15:8]  = wdata_q[7:0];
                    default: merged_c[7:0] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged_c[15:0]  = wdata_q[15:0];
                else           merged_c[31:16] = wdata_q[15:0];
            end
            default: merged_c = wdata_q;
        endcase
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept_c = 1'b1;
                    if (req_err_c)                          state_d = RESP;
                    else if (bus.we && bus.size == 2'b10)   state_d = WR;
                    else                                    state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered results
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                we_q    <= bus.we;
                sign_q  <= bus.sign_ext;
                size_q  <= bus.size;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                err_q   <= req_err_c;
            end
            if (state_q == RD) begin
                word_q <= bus.mem_rdata;
                if (!we_q) rdata_q <= load_ext_c;
            end
        end
    end

    // Outputs are plain decodes of registered state; the write enable is gated
    // by Reset so a reset landing on a WR cycle never reaches the RAM.
    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = (state_q == RESP);
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_rd    = (state_q == RD);
    assign bus.mem_wr    = (state_q == WR) && !Reset;
    assign bus.mem_addr  = (state_q == RD || state_q == WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata = (state_q == WR) ? merged_c : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-byte word RAM model that
// writes on the falling edge and reads combinationally.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int unsigned MEM_BYTES = 64;

    logic clk = 1'b0;
    logic Reset;
    logic [31:0] ram [16];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc [8];
    logic [31:0] last_wdata = 32'h0;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr[5:2]];

    always @(negedge clk) begin
        if (bus.mem_wr) begin
            ram[bus.mem_addr[5:2]] <= bus.mem_wdata;
            last_wdata = bus.mem_wdata;
            wr_cnt++;
        end
        if (bus.mem_rd) rd_cnt++;
        if (bus.done)   done_cnt++;
    end

    always @(posedge clk) begin
        if (!Reset && bus.req && bus.ready) begin
            acc_cyc[acc_n % 8] = cyc;
            acc_n++;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    // Issue one request; lat counts cycles from the accept cycle to the done cycle
    task automatic do_op(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int rd_ops, output int wr_ops);
        int rd_base, wr_base;
        wait_ready();
        rd_base = rd_cnt;
        wr_base = wr_cnt;
        bus.req = 1'b1; bus.we = we; bus.size = size; bus.sign_ext = sext;
        bus.addr = addr; bus.wdata = wdata;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd_ops = rd_cnt - rd_base;
        wr_ops = wr_cnt - wr_base;
    endtask

    initial begin
        int lat, rd_ops, wr_ops, done_base, wr_base, acc_base, n_done, guard;
        int done_c [2];
        logic [31:0] prev_rdata;

        Reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;

        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_ctl", {30'h0, bus.mem_rd, bus.mem_wr}, 32'h0);

        // Word load
        ram[2] = 32'h11223344;
        do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd_ops, wr_ops);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rdata", bus.rdata, 32'h11223344);
        check("lw_err", 32'(bus.err), 32'd0);
        check("lw_rd_ops", 32'(rd_ops), 32'd1);
        check("lw_wr_ops", 32'(wr_ops), 32'd0);

        // Byte loads, zero- and sign-extended
        do_op(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, lat, rd_ops, wr_ops);
        check("lbu_rdata", bus.rdata, 32'h00000022);
        ram[2] = 32'h11A53344;
        do_op(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, lat, rd_ops, wr_ops);
        check("lb_rdata", bus.rdata, 32'hFFFFFFA5);

        // Half loads: low half sign-extended, high half zero-extended
        ram[2] = 32'h1122F344;
        do_op(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, lat, rd_ops, wr_ops);
        check("lh_rdata", bus.rdata, 32'hFFFFF344);
        do_op(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, lat, rd_ops, wr_ops);
        check("lhu_hi_rdata", bus.rdata, 32'h00001122);

        // Byte store as read-modify-write
        ram[2] = 32'h11223344;
        do_op(1'b1, 2'b00, 1'b0, 32'hB, 32'h000000EE, lat, rd_ops, wr_ops);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_wdata", last_wdata, 32'h112233EE);
        check("sb_ops", 32'(rd_ops * 16 + wr_ops), 32'h11);
        check("sb_rdata_kept", bus.rdata, 32'h00001122);
        do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd_ops, wr_ops);
        check("sb_readback", bus.rdata, 32'h112233EE);

        // Half store into the upper half, word store at a new address
        do_op(1'b1, 2'b01, 1'b0, 32'h8, 32'h1234BEEF, lat, rd_ops, wr_ops);
        check("sh_ram", ram[2], 32'hBEEF33EE);
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, lat, rd_ops, wr_ops);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_ops", 32'(rd_ops * 16 + wr_ops), 32'h01);
        check("sw_ram", ram[4], 32'h12345678);

        // Highest legal word is accepted
        ram[15] = 32'h0BADF00D;
        do_op(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, lat, rd_ops, wr_ops);
        check("lw_top_err", 32'(bus.err), 32'd0);
        check("lw_top_rdata", bus.rdata, 32'h0BADF00D);

        // Error requests: no RAM access, rdata untouched, one-cycle response
        prev_rdata = bus.rdata;
        ram[1] = 32'hA1B2C3D4;
        do_op(1'b1, 2'b01, 1'b0, 32'h9, 32'h0000FFFF, lat, rd_ops, wr_ops);
        check("e_sh_odd", {16'(lat), 4'(rd_ops), 4'(wr_ops), 7'h0, bus.err}, {16'd1, 4'd0, 4'd0, 7'h0, 1'b1});
        do_op(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, rd_ops, wr_ops);
        check("e_lw_mis", {16'(lat), 4'(rd_ops), 4'(wr_ops), 7'h0, bus.err}, {16'd1, 4'd0, 4'd0, 7'h0, 1'b1});
        do_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF, lat, rd_ops, wr_ops);
        check("e_sw_range", {16'(lat), 4'(rd_ops), 4'(wr_ops), 7'h0, bus.err}, {16'd1, 4'd0, 4'd0, 7'h0, 1'b1});
        do_op(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rd_ops, wr_ops);
        check("e_size11", {16'(lat), 4'(rd_ops), 4'(wr_ops), 7'h0, bus.err}, {16'd1, 4'd0, 4'd0, 7'h0, 1'b1});
        do_op(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, rd_ops, wr_ops);
        check("e_lb_range", 32'(bus.err), 32'd1);
        check("e_rdata_kept", bus.rdata, prev_rdata);
        check("e_ram1", ram[1], 32'hA1B2C3D4);
        check("e_ram2", ram[2], 32'hBEEF33EE);
        check("e_ram0", ram[0], 32'h0);

        // Reset landing on the WR cycle of a word store
        wait_ready();
        ram[1] = 32'hCAFEF00D;
        done_base = done_cnt;
        wr_base = wr_cnt;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 32'h4; bus.wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.req = 1'b0;
        Reset = 1'b1;
        #1;
        check("rst_wr_mem_wr", 32'(bus.mem_wr), 32'd0);
        @(posedge clk); #1;
        Reset = 1'b0;
        check("rst_wr_ready", 32'(bus.ready), 32'd1);
        check("rst_wr_done", 32'(bus.done), 32'd0);
        check("rst_wr_rdata", bus.rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_no_done", 32'(done_cnt - done_base), 32'd0);
        check("rst_wr_no_write", 32'(wr_cnt - wr_base), 32'd0);
        check("rst_wr_ram", ram[1], 32'hCAFEF00D);

        // req held high across two word loads
        wait_ready();
        acc_base = acc_n;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 32'h10; bus.wdata = 32'h0;
        n_done = 0;
        guard = 0;
        while (n_done < 2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
            if (bus.done) begin
                done_c[n_done] = cyc;
                n_done++;
                check("hold_rdata", bus.rdata, 32'h12345678);
            end
        end
        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_dones", 32'(n_done), 32'd2);
        check("hold_accepts", 32'(acc_n - acc_base), 32'd2);
        check("hold_acc_spacing", 32'(acc_cyc[(acc_base + 1) % 8] - acc_cyc[acc_base % 8]), 32'd3);
        check("hold_acc_after_done", 32'(acc_cyc[(acc_base + 1) % 8] - done_c[0]), 32'd1);
        check("hold_done_spacing", 32'(done_c[1] - done_c[0]), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
